// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Control-unit / memory / PC-register signal bundle for the
//               program-counter sequencer. The master side is the
//               environment: control unit requests and memory ready.
//               The slave side is the sequencer: strobes and status.
// Revision    : 1.0  initial release
// ============================================================================
interface pc_sequencer_if;

  // Requests from the control unit and ready from memory
  logic fetch_req;
  logic jump_req;
  logic save_req;
  logic mem_rdy;

  // Status back to the control unit
  logic busy;
  logic done;
  logic err;

  // Memory read enable
  logic mem_oe;

  // PC register strobes
  logic pc_cs;
  logic pc_oe_a;
  logic pc_cnt_en;
  logic pc_we_l;
  logic pc_oe_l;
  logic pc_we_h;
  logic pc_oe_h;

  modport master (
    output fetch_req, jump_req, save_req, mem_rdy,
    input  busy, done, err, mem_oe,
    input  pc_cs, pc_oe_a, pc_cnt_en, pc_we_l, pc_oe_l, pc_we_h, pc_oe_h
  );

  modport slave (
    input  fetch_req, jump_req, save_req, mem_rdy,
    output busy, done, err, mem_oe,
    output pc_cs, pc_oe_a, pc_cnt_en, pc_we_l, pc_oe_l, pc_we_h, pc_oe_h
  );

endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Moore control FSM sequencing the program-counter register:
//               instruction fetch (address out, wait for memory, increment),
//               two-byte jump load and two-byte PC save. Requests are levels
//               sampled only in IDLE; every strobe decodes from registered
//               state so there is no input-to-output combinational path.
// Options     : PC_SEQ_TIMEOUT_EN - abort a fetch with an err pulse after
//               TIMEOUT consecutive F_WAIT cycles without mem_rdy.
// Revision    : 1.0  initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module pc_sequencer #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int TIMEOUT    = 15
) (
  input wire            clk,
  input wire            reset,
  pc_sequencer_if.slave bus_if
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
      $error("pc_sequencer: TIMEOUT must be in 1..255");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
      $error("pc_sequencer: DATA_WIDTH must be at least 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_WAIT = 3'd1,
    F_INC  = 3'd2,
    J_L    = 3'd3,
    J_H    = 3'd4,
    S_L    = 3'd5,
    S_H    = 3'd6
  } state_t;

  state_t state_q;
  state_t state_d;

  // Fetch abort request; only ever high in F_WAIT
  logic   timeout_w;
  // Registered abort flag, becomes the one-cycle err pulse in IDLE
  logic   err_w;

  // Decoded outputs
  logic   busy_w;
  logic   done_w;
  logic   mem_oe_w;
  logic   pc_cs_w;
  logic   pc_oe_a_w;
  logic   pc_cnt_en_w;
  logic   pc_we_l_w;
  logic   pc_oe_l_w;
  logic   pc_we_h_w;
  logic   pc_oe_h_w;

  // --------------------------------------------------------------------------
  // Optional fetch timeout
  // --------------------------------------------------------------------------
`ifdef PC_SEQ_TIMEOUT_EN
  // Never narrower than 8 bits so the full 1..255 TIMEOUT range fits
  localparam int CNT_W = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             err_q;
  logic             err_d;

  // The cycle that would bring the count up to TIMEOUT aborts, unless
  // mem_rdy arrives in that same cycle (memory wins the race).
  assign timeout_w = (state_q == F_WAIT) && !bus_if.mem_rdy &&
                     ((wait_cnt_q + CNT_W'(1)) >= TIMEOUT_CNT);

  // Wait-counter next state: cleared while idle, counts stalled fetch cycles
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    err_d      = timeout_w;
    if (state_q == IDLE) begin
      wait_cnt_d = '0;
    end else if ((state_q == F_WAIT) && !bus_if.mem_rdy) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Wait counter and err flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_w = err_q;
`else
  // Without the timeout a fetch waits on memory indefinitely
  assign timeout_w = 1'b0;
  assign err_w     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // Asynchronous reset returns to IDLE at once, clearing every strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // Requests are only looked at in IDLE; jump beats save beats fetch
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus_if.jump_req) begin
          state_d = J_L;
        end else if (bus_if.save_req) begin
          state_d = S_L;
        end else if (bus_if.fetch_req) begin
          state_d = F_WAIT;
        end
      end
      F_WAIT: begin
        if (bus_if.mem_rdy) begin
          state_d = F_INC;
        end else if (timeout_w) begin
          state_d = IDLE;
        end
      end
      F_INC:   state_d = IDLE;
      J_L:     state_d = J_H;
      J_H:     state_d = IDLE;
      S_L:     state_d = S_H;
      S_H:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  // Strobes depend on state_q only; at most one PC data strobe per state
  always_comb begin
    busy_w      = 1'b0;
    done_w      = 1'b0;
    mem_oe_w    = 1'b0;
    pc_cs_w     = 1'b0;
    pc_oe_a_w   = 1'b0;
    pc_cnt_en_w = 1'b0;
    pc_we_l_w   = 1'b0;
    pc_oe_l_w   = 1'b0;
    pc_we_h_w   = 1'b0;
    pc_oe_h_w   = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      F_WAIT: begin
        busy_w    = 1'b1;
        pc_cs_w   = 1'b1;
        pc_oe_a_w = 1'b1;
        mem_oe_w  = 1'b1;
      end
      F_INC: begin
        busy_w      = 1'b1;
        pc_cs_w     = 1'b1;
        pc_cnt_en_w = 1'b1;
        done_w      = 1'b1;
      end
      J_L: begin
        busy_w    = 1'b1;
        pc_cs_w   = 1'b1;
        pc_we_l_w = 1'b1;
      end
      J_H: begin
        busy_w    = 1'b1;
        pc_cs_w   = 1'b1;
        pc_we_h_w = 1'b1;
        done_w    = 1'b1;
      end
      S_L: begin
        busy_w    = 1'b1;
        pc_cs_w   = 1'b1;
        pc_oe_l_w = 1'b1;
      end
      S_H: begin
        busy_w    = 1'b1;
        pc_cs_w   = 1'b1;
        pc_oe_h_w = 1'b1;
        done_w    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus_if.busy      = busy_w;
  assign bus_if.done      = done_w;
  assign bus_if.err       = err_w;
  assign bus_if.mem_oe    = mem_oe_w;
  assign bus_if.pc_cs     = pc_cs_w;
  assign bus_if.pc_oe_a   = pc_oe_a_w;
  assign bus_if.pc_cnt_en = pc_cnt_en_w;
  assign bus_if.pc_we_l   = pc_we_l_w;
  assign bus_if.pc_oe_l   = pc_oe_l_w;
  assign bus_if.pc_we_h   = pc_we_h_w;
  assign bus_if.pc_oe_h   = pc_oe_h_w;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer with a
//               behavioural 16-bit PC register and byte-wide data bus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 3;
  localparam int WAIT_CYC   = 3;
`else
  localparam int TB_TIMEOUT = 15;
  localparam int WAIT_CYC   = 5;
`endif

  // Output vector bit positions
  localparam logic [10:0] O_BUSY  = 11'h400;
  localparam logic [10:0] O_DONE  = 11'h200;
  localparam logic [10:0] O_ERR   = 11'h100;
  localparam logic [10:0] O_MEMOE = 11'h080;
  localparam logic [10:0] O_CS    = 11'h040;
  localparam logic [10:0] O_OEA   = 11'h020;
  localparam logic [10:0] O_CNT   = 11'h010;
  localparam logic [10:0] O_WEL   = 11'h008;
  localparam logic [10:0] O_OEL   = 11'h004;
  localparam logic [10:0] O_WEH   = 11'h002;
  localparam logic [10:0] O_OEH   = 11'h001;

  // Expected output vector per state
  localparam logic [10:0] E_IDLE  = 11'h000;
  localparam logic [10:0] E_FWAIT = O_BUSY | O_MEMOE | O_CS | O_OEA;
  localparam logic [10:0] E_FINC  = O_BUSY | O_CS | O_CNT | O_DONE;
  localparam logic [10:0] E_JL    = O_BUSY | O_CS | O_WEL;
  localparam logic [10:0] E_JH    = O_BUSY | O_CS | O_WEH | O_DONE;
  localparam logic [10:0] E_SL    = O_BUSY | O_CS | O_OEL;
  localparam logic [10:0] E_SH    = O_BUSY | O_CS | O_OEH | O_DONE;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  pc_sequencer_if bus_if ();

  pc_sequencer #(
    .DATA_WIDTH (8),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  wire [10:0] outs = {bus_if.busy, bus_if.done, bus_if.err, bus_if.mem_oe,
                      bus_if.pc_cs, bus_if.pc_oe_a, bus_if.pc_cnt_en,
                      bus_if.pc_we_l, bus_if.pc_oe_l, bus_if.pc_we_h,
                      bus_if.pc_oe_h};

  // Behavioural PC register and data bus
  logic [15:0] pc;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;
  logic [7:0]  data_drv = 8'h00;
  wire  [7:0]  data_bus = bus_if.pc_oe_l ? pc[7:0] :
                          (bus_if.pc_oe_h ? pc[15:8] : data_drv);

  always @(posedge clk) begin
    if (pc_load) begin
      pc <= pc_load_val;
    end else if (bus_if.pc_cs) begin
      if (bus_if.pc_cnt_en) pc <= pc + 16'd1;
      if (bus_if.pc_we_l)   pc[7:0]  <= data_bus;
      if (bus_if.pc_we_h)   pc[15:8] <= data_bus;
    end
  end

  task automatic load_pc(input logic [15:0] v);
    pc_load     = 1'b1;
    pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.fetch_req = 1'b0;
    bus_if.jump_req  = 1'b0;
    bus_if.save_req  = 1'b0;
    bus_if.mem_rdy   = 1'b0;
    reset = 1'b0;
    load_pc(16'h0000);
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== E_IDLE) begin
      failures++;
      $display("FAIL reset_held outs=%b expected=%b", outs, E_IDLE);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== E_IDLE) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d outs=%b expected=%b", i, outs, E_IDLE);
      end
    end
    // Start a fetch, then pull reset in the middle of F_WAIT
    bus_if.fetch_req = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== E_FWAIT) begin
      failures++;
      $display("FAIL reset_fwait_entry outs=%b expected=%b", outs, E_FWAIT);
    end
    bus_if.fetch_req = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs !== E_IDLE) begin
      failures++;
      $display("FAIL reset_async outs=%b expected=%b", outs, E_IDLE);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== E_IDLE || pc !== 16'h0000) begin
      failures++;
      $display("FAIL reset_after outs=%b pc=%h expected=%b pc=0000", outs, pc, E_IDLE);
    end
  endtask

  task automatic test_fetch_immediate();
    load_pc(16'h00FF);
    bus_if.fetch_req = 1'b1;
    bus_if.mem_rdy   = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== E_FWAIT) begin
      failures++;
      $display("FAIL fetch_imm_wait outs=%b expected=%b", outs, E_FWAIT);
    end
    bus_if.fetch_req = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== E_FINC) begin
      failures++;
      $display("FAIL fetch_imm_inc outs=%b expected=%b", outs, E_FINC);
    end
    bus_if.mem_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== E_IDLE || pc !== 16'h0100) begin
      failures++;
      $display("FAIL fetch_imm_end outs=%b pc=%h expected=%b pc=0100", outs, pc, E_IDLE);
    end
  endtask

  // Delayed mem_rdy; PC starts at all-ones to cover the wrap to zero
  task automatic test_fetch_wait();
    load_pc(16'hFFFF);
    bus_if.fetch_req = 1'b1;
    bus_if.mem_rdy   = 1'b0;
    for (int k = 1; k <= WAIT_CYC; k++) begin
      @(negedge clk);
      checks++;
      if (outs !== E_FWAIT) begin
        failures++;
        $display("FAIL fetch_wait cycle=%0d outs=%b expected=%b", k, outs, E_FWAIT);
      end
      bus_if.fetch_req = 1'b0;
      bus_if.mem_rdy   = (k == WAIT_CYC);
    end
    @(negedge clk);
    checks++;
    if (outs !== E_FINC) begin
      failures++;
      $display("FAIL fetch_wait_inc outs=%b expected=%b", outs, E_FINC);
    end
    bus_if.mem_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== E_IDLE || pc !== 16'h0000) begin
      failures++;
      $display("FAIL fetch_wait_end outs=%b pc=%h expected=%b pc=0000", outs, pc, E_IDLE);
    end
  endtask

  task automatic test_jump_save();
    bus_if.jump_req = 1'b1;
    data_drv        = 8'h34;
    @(negedge clk);
    checks++;
    if (outs !== E_JL) begin
      failures++;
      $display("FAIL jump_low outs=%b expected=%b", outs, E_JL);
    end
    bus_if.jump_req = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== E_JH) begin
      failures++;
      $display("FAIL jump_high outs=%b expected=%b", outs, E_JH);
    end
    data_drv = 8'h12;
    @(negedge clk);
    checks++;
    if (outs !== E_IDLE || pc !== 16'h1234) begin
      failures++;
      $display("FAIL jump_end outs=%b pc=%h expected=%b pc=1234", outs, pc, E_IDLE);
    end
    data_drv        = 8'h00;
    bus_if.save_req = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== E_SL || data_bus !== 8'h34) begin
      failures++;
      $display("FAIL save_low outs=%b bus=%h expected=%b bus=34", outs, data_bus, E_SL);
    end
    bus_if.save_req = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== E_SH || data_bus !== 8'h12) begin
      failures++;
      $display("FAIL save_high outs=%b bus=%h expected=%b bus=12", outs, data_bus, E_SH);
    end
    @(negedge clk);
    checks++;
    if (outs !== E_IDLE || pc !== 16'h1234) begin
      failures++;
      $display("FAIL save_end outs=%b pc=%h expected=%b pc=1234", outs, pc, E_IDLE);
    end
  endtask

  // All three requests at once; each requester drops in the cycle after its done
  task automatic test_back_to_back();
    logic [10:0] exp_tab [9];
    exp_tab = '{E_JL, E_JH, E_IDLE, E_SL, E_SH, E_IDLE, E_FWAIT, E_FINC, E_IDLE};
    bus_if.jump_req  = 1'b1;
    bus_if.save_req  = 1'b1;
    bus_if.fetch_req = 1'b1;
    bus_if.mem_rdy   = 1'b1;
    data_drv         = 8'hAB;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      checks++;
      if (outs !== exp_tab[n]) begin
        failures++;
        $display("FAIL b2b_step%0d outs=%b expected=%b", n, outs, exp_tab[n]);
      end
      if (n == 1) data_drv = 8'hCD;
      if (n == 2) bus_if.jump_req  = 1'b0;
      if (n == 5) bus_if.save_req  = 1'b0;
      if (n == 8) bus_if.fetch_req = 1'b0;
    end
    bus_if.mem_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== E_IDLE || pc !== 16'hCDAC) begin
      failures++;
      $display("FAIL b2b_end outs=%b pc=%h expected=%b pc=cdac", outs, pc, E_IDLE);
    end
  endtask

`ifdef PC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    load_pc(16'h00A5);
    bus_if.fetch_req = 1'b1;
    bus_if.mem_rdy   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (outs !== E_FWAIT) begin
        failures++;
        $display("FAIL timeout_wait cycle=%0d outs=%b expected=%b", k, outs, E_FWAIT);
      end
      bus_if.fetch_req = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (outs !== O_ERR || pc !== 16'h00A5) begin
      failures++;
      $display("FAIL timeout_abort outs=%b pc=%h expected=%b pc=00a5", outs, pc, O_ERR);
    end
    @(negedge clk);
    checks++;
    if (outs !== E_IDLE) begin
      failures++;
      $display("FAIL timeout_err_pulse outs=%b expected=%b", outs, E_IDLE);
    end
    // mem_rdy on the third cycle beats the timeout
    bus_if.fetch_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (outs !== E_FWAIT) begin
        failures++;
        $display("FAIL race_wait cycle=%0d outs=%b expected=%b", k, outs, E_FWAIT);
      end
      bus_if.fetch_req = 1'b0;
      bus_if.mem_rdy   = (k == 3);
    end
    @(negedge clk);
    checks++;
    if (outs !== E_FINC) begin
      failures++;
      $display("FAIL race_inc outs=%b expected=%b", outs, E_FINC);
    end
    bus_if.mem_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== E_IDLE || pc !== 16'h00A6) begin
      failures++;
      $display("FAIL race_end outs=%b pc=%h expected=%b pc=00a6", outs, pc, E_IDLE);
    end
  endtask
`else
  // Without the timeout a stalled fetch never aborts and err stays low
  task automatic test_long_wait();
    load_pc(16'h0042);
    bus_if.fetch_req = 1'b1;
    bus_if.mem_rdy   = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (outs !== E_FWAIT) begin
        failures++;
        $display("FAIL long_wait cycle=%0d outs=%b expected=%b", k, outs, E_FWAIT);
      end
      bus_if.fetch_req = 1'b0;
      bus_if.mem_rdy   = (k == 20);
    end
    @(negedge clk);
    checks++;
    if (outs !== E_FINC) begin
      failures++;
      $display("FAIL long_wait_inc outs=%b expected=%b", outs, E_FINC);
    end
    bus_if.mem_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== E_IDLE || pc !== 16'h0043) begin
      failures++;
      $display("FAIL long_wait_end outs=%b pc=%h expected=%b pc=0043", outs, pc, E_IDLE);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_immediate();
    test_fetch_wait();
    test_jump_save();
    test_back_to_back();
`ifdef PC_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control FSM that sequences the program-counter register: instruction fetch, two-byte jump load and two-byte PC save.
- Takes level requests from the CPU control unit and drives the PC register's CS/OE_A/CNT_EN/WE_L/OE_L/WE_H/OE_H strobes, plus the memory read enable.
- Sits between the control unit, the PC register and memory.

Parameters:
- DATA_WIDTH, `DATA_WIDTH, byte width of the PC halves and data bus; used only for timeout-counter sizing.
- TIMEOUT, 15, F_WAIT cycles without mem_rdy before abort (used only when PC_SEQ_TIMEOUT_EN is defined); legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_req  input  1  request: place PC on address bus, read memory, increment PC.
- jump_req  input  1  request: load PC from data bus, low byte then high byte.
- save_req  input  1  request: drive PC onto data bus, low byte then high byte.
- mem_rdy  input  1  memory read data valid.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in the final cycle of an operation.
- err  output  1  one-cycle pulse on fetch timeout.
- mem_oe  output  1  memory read enable.
- pc_cs, pc_oe_a, pc_cnt_en, pc_we_l, pc_oe_l, pc_we_h, pc_oe_h  output  1 each  PC register strobes.

Behaviour:
- Moore FSM: all outputs decode from the state register only; there is no combinational input-to-output path.
- States: IDLE, F_WAIT, F_INC, J_L, J_H, S_L, S_H.
- Reset (reset=0) forces state IDLE and all outputs 0 immediately, including mid-operation. A partially loaded PC is left as-is.
- IDLE: all outputs 0. Requests are sampled only here. Priority is jump_req > save_req > fetch_req. Next state is J_L, S_L or F_WAIT respectively; with no request, stay in IDLE.
- F_WAIT:
  - Outputs: pc_cs=1, pc_oe_a=1, mem_oe=1.
  - Stay while mem_rdy=0; go to F_INC on the edge where mem_rdy=1.
- F_INC:
  - Outputs: pc_cs=1, pc_cnt_en=1, done=1; the PC increments by exactly 1 at this edge.
  - Next state is IDLE.
  - PC wrap from all-ones to 0 is legal and is not flagged.
- J_L: pc_cs=1, pc_we_l=1. Requester holds the low byte on the data bus. Next state is J_H.
- J_H: pc_cs=1, pc_we_h=1, done=1. Requester holds the high byte. Next state is IDLE.
- S_L: pc_cs=1, pc_oe_l=1 (PC low byte drives the bus). Next state is S_H.
- S_H: pc_cs=1, pc_oe_h=1, done=1. Next state is IDLE.
- Timing:
  - Fetch takes 2 + wait cycles after acceptance; jump and save take exactly 2 cycles.
  - There is always one IDLE cycle between operations.
- Requests are level-sensitive. The requester drops its request in the cycle after done; a request still high in IDLE starts a new operation.
- Request changes while busy are ignored.
- Invariants:
  - At most one of pc_cnt_en, pc_we_l, pc_we_h, pc_oe_l, pc_oe_h is high in any cycle.
  - pc_oe_a and mem_oe are high only in F_WAIT.
  - pc_cs is high in every non-IDLE state.

Optional Feature:
- Macro PC_SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to F_WAIT and increments each F_WAIT cycle with mem_rdy=0.
  - When the count reaches TIMEOUT with mem_rdy still 0, the FSM returns to IDLE with err=1 for one cycle and the PC is not incremented.
  - done is not asserted on abort.
  - mem_rdy=1 on the same cycle the count reaches TIMEOUT wins: the fetch proceeds normally.
- Undefined: F_WAIT waits indefinitely; err is tied to 0.

Test Plan:
- Reset held low, then released with no requests -> all outputs 0, busy=0 for 10 cycles; assert reset mid-F_WAIT -> outputs 0 in the same cycle, state IDLE.
- PC=16'h00FF, fetch_req with mem_rdy=1 immediately -> pc_oe_a/mem_oe for 1 cycle, pc_cnt_en + done for 1 cycle, PC=16'h0100.
- fetch_req with mem_rdy delayed 4 cycles -> F_WAIT lasts 5 cycles, single increment, one done pulse.
- jump_req with bus 8'h34 then 8'h12 -> pc_we_l cycle, then pc_we_h + done, PC=16'h1234; then save_req -> bus shows 8'h34 then 8'h12.
- jump_req, save_req and fetch_req raised together -> jump executes first; save, then fetch follow in later IDLE-accepted operations.
- PC_SEQ_TIMEOUT_EN, TIMEOUT=3, mem_rdy held 0 -> err pulse after 3 F_WAIT cycles, no done, PC unchanged; repeat with mem_rdy=1 on cycle 3 -> normal increment, err=0.
